ps2_transmitter: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte, such as LED set (0xED) or reset (0xFF), from the FPGA to the keyboard over the same open-drain kclk/kdata lines that the keyboard receiver listens on. It performs the PS/2 request-to-send sequence, then shifts the byte LSB-first with odd parity and a stop bit on the device-generated clock. It optionally checks the device acknowledge bit and reports completion or error with single-cycle pulses.

---
 rtl/ps2_pkg.sv | 9 +
 rtl/ps2_line_filter.sv | 26 ++
 rtl/ps2_transmitter.sv | 102 ++++++++++
 tb/tb_ps2_transmitter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared states, frame constants and parity helper for the PS/2 transmitter
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, DONE} ps2_state_t;
  localparam int PS2_FRAME_BITS = 10;
  localparam int PS2_ACK_EDGE = 11;
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer plus a stable-level filter for one PS/2 line
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 19
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(FILTER_CYCLES + 1);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sync <= 2'b11;
      cnt  <= '0;
      dout <= 1'b1;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) cnt <= '0;
      else if (cnt == CW'(FILTER_CYCLES - 1)) begin
        cnt  <= '0;
        dout <= sync[1];
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command sender; define PS2_TX_ACK_CHECK_EN to check the device ACK bit
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_CYCLES  = 19
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       kclk,
  input  logic       kdata,
  output logic       kclk_oe,
  output logic       kdata_oe
);
  localparam int CW = $clog2((INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
`ifdef PS2_TX_ACK_CHECK_EN
  localparam ps2_state_t AFTER_STOP = ACK;
`else
  localparam ps2_state_t AFTER_STOP = WAIT_IDLE;
`endif
  ps2_state_t                state, state_n;
  logic [CW-1:0]             cnt;
  logic [3:0]                bit_cnt;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic                      kclk_f, kdata_f, kclk_d, fall, tmo, fail, err_q;
  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filt (
    .clk(clk), .rstn(rstn), .din(kclk), .dout(kclk_f)
  );
  ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filt (
    .clk(clk), .rstn(rstn), .din(kdata), .dout(kdata_f)
  );
  assign fall     = kclk_d & ~kclk_f;
  assign tmo      = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign tx_ready = state == IDLE;
  assign busy     = ~tx_ready;
  assign tx_done  = (state == DONE) & ~err_q;
  assign tx_err   = (state == DONE) & err_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      frame   <= '1;
      err_q   <= 1'b0;
      kclk_d  <= 1'b1;
    end else begin
      state  <= state_n;
      err_q  <= fail;
      kclk_d <= kclk_f;
      cnt    <= (state == IDLE || state == START) ? '0 : cnt + 1'b1;
      if (tx_valid && tx_ready) begin
        frame   <= {1'b1, odd_parity(tx_data), tx_data};
        bit_cnt <= '0;
      end else if (state == SHIFT && fall) begin
        bit_cnt <= bit_cnt + 4'd1;
        // the first fall only ends the start bit; data[0] is already at frame[0]
        if (bit_cnt != 4'd0) frame <= {1'b1, frame[PS2_FRAME_BITS-1:1]};
      end
    end
  always_comb begin
    state_n  = state;
    fail     = 1'b0;
    kclk_oe  = 1'b0;
    kdata_oe = 1'b0;
    case (state)
      IDLE:    state_n = tx_valid ? INHIBIT : IDLE;
      INHIBIT: begin
        kclk_oe = 1'b1;
        state_n = (cnt == CW'(INHIBIT_CYCLES - 1)) ? START : INHIBIT;
      end
      START: begin
        kclk_oe  = 1'b1;
        kdata_oe = 1'b1;
        state_n  = SHIFT;
      end
      SHIFT: begin
        kdata_oe = (bit_cnt == 4'd0) | ~frame[0];
        fail     = tmo;
        state_n  = tmo ? DONE : (fall && bit_cnt == 4'(PS2_FRAME_BITS - 1)) ? AFTER_STOP : SHIFT;
      end
`ifdef PS2_TX_ACK_CHECK_EN
      ACK: begin
        fail    = tmo | (fall & bit_cnt == 4'(PS2_ACK_EDGE - 1) & kdata_f);
        state_n = fail ? DONE : fall ? WAIT_IDLE : ACK;
      end
`endif
      WAIT_IDLE: begin
        fail    = tmo;
        state_n = (tmo || (kclk_f && kdata_f)) ? DONE : WAIT_IDLE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_transmitter.sv
`timescale 1ns/1ps
// tb_ps2_transmitter: directed bench with a PS/2 device model clocking kclk at 10 kHz (1 MHz clk)
module tb_ps2_transmitter;
  localparam int INH = 100;
  localparam int TMO = 3000;
  localparam int FLT = 19;
  logic       clk = 1'b0, rstn = 1'b1, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_done, tx_err, busy, kclk_oe, kdata_oe, kclk, kdata;
  logic       dev_clk_lo = 1'b0, dev_dat_lo = 1'b0;
  logic       busy_q = 1'b0, kclk_oe_q = 1'b0, err_oe = 1'b0;
  int n_chk = 0, n_fail = 0, done_cnt = 0, err_cnt = 0, starts = 0, proto_bad = 0;
  int cyc = 0, t_fall = 0, t_err = 0, t_done = 0, t_acc = 0;
  assign kclk  = ~(kclk_oe | dev_clk_lo);
  assign kdata = ~(kdata_oe | dev_dat_lo);
  always #500 clk = ~clk;
  ps2_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_CYCLES(FLT)) dut (
    .clk(clk), .rstn(rstn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err), .busy(busy), .kclk(kclk), .kdata(kdata),
    .kclk_oe(kclk_oe), .kdata_oe(kdata_oe)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (tx_done) begin done_cnt++; t_done = cyc; end
    if (tx_err) begin err_cnt++; t_err = cyc; err_oe = kclk_oe | kdata_oe; end
    if (busy && !busy_q) starts++;
    if (kclk_oe_q && !kclk_oe) t_fall = cyc;
    if (tx_valid && tx_ready) t_acc = cyc;
    if (rstn && (tx_ready == busy || (tx_done && tx_err))) proto_bad++;
    busy_q    = busy;
    kclk_oe_q = kclk_oe;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask
  // waits for the start bit, then clocks nf bits, sampling the line on each rising edge
  task automatic dev(input bit ack, input int nf, output logic [9:0] bits);
    int w = 0;
    bits = '0;
    while (!(kdata === 1'b0 && kclk === 1'b1) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("dev_start", 32'(w < 2000), 32'd1);
    if (w >= 2000) return;
    #100;
    for (int i = 1; i <= nf; i++) begin
      #50000 dev_clk_lo = 1'b1;
      #50000 if (i <= 10) bits[i-1] = kdata;
      dev_clk_lo = 1'b0;
      if (i == 10 && ack) dev_dat_lo = 1'b1;
    end
    dev_dat_lo = 1'b0;
  endtask
  task automatic wait_end(input int d0, input int e0);
    int w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 6000) begin
      @(negedge clk);
      w++;
    end
    check("end_wait", 32'(w < 6000), 32'd1);
    repeat (30) @(negedge clk);
  endtask
  initial begin
    logic [9:0] b;
    int d0, e0, s0, td1;
    #200 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outs", 32'({tx_ready, busy, kclk_oe, kdata_oe, tx_done, tx_err}), 32'b100000);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED); dev(1'b1, 11, b); wait_end(d0, e0);
    check("ed_bits", 32'(b), 32'h3ED);
    check("ed_done", done_cnt - d0, 32'd1);
    check("ed_err", err_cnt - e0, 32'd0);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h01); dev(1'b1, 11, b); wait_end(d0, e0);
    check("01_bits", 32'(b), 32'h201);
    check("01_done", done_cnt - d0, 32'd1);
    check("01_err", err_cnt - e0, 32'd0);
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED); dev(1'b0, 11, b); wait_end(d0, e0);
`ifdef PS2_TX_ACK_CHECK_EN
    check("nack_err", err_cnt - e0, 32'd1);
    check("nack_done", done_cnt - d0, 32'd0);
`else
    check("nack_done", done_cnt - d0, 32'd1);
    check("nack_err", err_cnt - e0, 32'd0);
`endif
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5); dev(1'b1, 0, b); wait_end(d0, e0);
    check("tmo_err", err_cnt - e0, 32'd1);
    check("tmo_done", done_cnt - d0, 32'd0);
    check("tmo_latency", t_err - t_fall, TMO);
    check("tmo_oe", 32'(err_oe), 32'd0);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00); dev(1'b1, 4, b);
    check("bit4_kdata_oe", 32'(kdata_oe), 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_oe", 32'({kclk_oe, kdata_oe}), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    repeat (5) @(negedge clk);
    rstn = 1'b1;
    repeat (30) @(negedge clk);
    check("rst_nopulse", (done_cnt - d0) + (err_cnt - e0), 32'd0);
    check("rst_ready_after", 32'(tx_ready), 32'd1);
    d0 = done_cnt; e0 = err_cnt;
    send(8'hFF); dev(1'b1, 11, b); wait_end(d0, e0);
    check("ff_bits", 32'(b), 32'h3FF);
    check("ff_done", done_cnt - d0, 32'd1);
    d0 = done_cnt; e0 = err_cnt; s0 = starts;
    @(negedge clk);
    tx_data  = 8'hF4;
    tx_valid = 1'b1;
    dev(1'b1, 11, b);
    check("f4_bits0", 32'(b), 32'h2F4);
    wait_end(d0, e0);
    td1 = t_done;
    dev(1'b1, 11, b);
    tx_valid = 1'b0;
    check("f4_bits1", 32'(b), 32'h2F4);
    wait_end(d0 + 1, e0);
    repeat (200) @(negedge clk);
    check("f4_done", done_cnt - d0, 32'd2);
    check("f4_starts", starts - s0, 32'd2);
    check("f4_gap", t_acc - td1, 32'd1);
    check("protocol", proto_bad, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
